fragment_writer: RTL

- Consumer end of the rasterizer fragment stream.
- Samples per-pixel fragments (valid/x/y) and the rasterizer done level, clips them to the framebuffer and converts x/y to a linear address.
- Buffers the resulting writes in a FIFO and issues them to the framebuffer memory port over a valid/ready handshake.
- Sits between the rasterizer and the framebuffer arbiter. Reports frame completion, overflow, and per-triangle statistics.

---
 rtl/fragment_writer.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/fragment_writer.sv
// Rasterizer fragment sink: clips fragments to the framebuffer, linearises x/y into an
// address and queues {addr, colour} writes in a fall-through FIFO toward the framebuffer port.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | no triangle in progress; fragments are still sampled
// ST_ACTIVE  | rasterizer busy; colour latched, counters running
// ST_DRAIN   | rasterizer done; waiting for stage register and FIFO to empty
module fragment_writer #(
   parameter int CORD_WIDTH  = 10,
   parameter int FB_WIDTH    = 640,
   parameter int FB_HEIGHT   = 480,
   parameter int ADDR_WIDTH  = 19,
   parameter int FB_BASE     = 0,
   parameter int COLOR_WIDTH = 16,
   parameter int FIFO_DEPTH  = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          i_fragment_valid,
   input  logic signed [CORD_WIDTH-1:0]  i_fragment_x,
   input  logic signed [CORD_WIDTH-1:0]  i_fragment_y,
   input  logic                          i_raster_done,
   input  logic [COLOR_WIDTH-1:0]        i_color,
   input  logic                          i_clear,
   output logic                          o_mem_valid,
   input  logic                          i_mem_ready,
   output logic [ADDR_WIDTH-1:0]         o_mem_addr,
   output logic [COLOR_WIDTH-1:0]        o_mem_data,
   output logic                          o_busy,
   output logic                          o_frame_done,
   output logic                          o_overflow,
   output logic [15:0]                   o_frag_count,
   output logic [15:0]                   o_clip_count
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int WW = CORD_WIDTH + 34;
   localparam int EW = ADDR_WIDTH + COLOR_WIDTH;
   localparam logic [15:0] CNT_MAX = 16'hFFFF;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACTIVE = 2'd1;
   localparam logic [1:0] ST_DRAIN  = 2'd2;

   logic [1:0]             state;
   logic [COLOR_WIDTH-1:0] color_q;
   logic                   stg_valid;
   logic                   stg_in_bounds;
   logic [ADDR_WIDTH-1:0]  stg_addr;
   logic [EW-1:0]          fifo_mem [FIFO_DEPTH];
   logic [PW-1:0]          wr_ptr;
   logic [PW-1:0]          rd_ptr;
   logic [PW:0]            fifo_count;
   logic                   frame_done_q;
   logic                   overflow_q;
   logic [15:0]            frag_cnt;
   logic [15:0]            clip_cnt;

   logic signed [WW-1:0]   x_w;
   logic signed [WW-1:0]   y_w;
   logic [ADDR_WIDTH-1:0]  x_a;
   logic [ADDR_WIDTH-1:0]  y_a;
   logic [ADDR_WIDTH-1:0]  addr_lin;
   logic                   in_bounds;
   logic [EW-1:0]          head;

   logic fifo_empty;
   logic fifo_full;
   logic pop;
   logic push_req;
   logic push;
   logic drop;
   logic clip;
   logic start;
   logic drain_done;

   assign x_w = WW'(i_fragment_x);
   assign y_w = WW'(i_fragment_y);
   assign in_bounds = !x_w[WW-1] && (x_w < WW'(FB_WIDTH)) &&
                      !y_w[WW-1] && (y_w < WW'(FB_HEIGHT));

   // Low address bits depend only on low operand bits, so the modulo-2^ADDR_WIDTH
   // result can be formed directly at ADDR_WIDTH.
   assign x_a      = ADDR_WIDTH'(i_fragment_x);
   assign y_a      = ADDR_WIDTH'(i_fragment_y);
   assign addr_lin = ADDR_WIDTH'(FB_BASE) + y_a * ADDR_WIDTH'(FB_WIDTH) + x_a;

   assign fifo_empty = (fifo_count == '0);
   assign fifo_full  = (fifo_count == (PW+1)'(FIFO_DEPTH));
   assign pop        = !fifo_empty && i_mem_ready;
   assign push_req   = stg_valid && stg_in_bounds;
   assign push       = push_req && (!fifo_full || pop);
   assign drop       = push_req && !push;
   assign clip       = stg_valid && !stg_in_bounds;
   assign start      = (state == ST_IDLE) && !i_raster_done;
   assign drain_done = (state == ST_DRAIN) && !stg_valid && fifo_empty;

   function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic inc);
      return (inc && (v != CNT_MAX)) ? v + 16'd1 : v;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:   if (!i_raster_done) state <= ST_ACTIVE;
            ST_ACTIVE: if (i_raster_done)  state <= ST_DRAIN;
            ST_DRAIN:  if (drain_done)     state <= ST_IDLE;
            default:                       state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stg_valid     <= 1'b0;
         stg_in_bounds <= 1'b0;
         stg_addr      <= '0;
      end else begin
         stg_valid     <= i_fragment_valid;
         stg_in_bounds <= in_bounds;
         stg_addr      <= addr_lin;
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= {stg_addr, color_q};
   end

   // A full FIFO still accepts when the head leaves on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         fifo_count <= fifo_count + (PW+1)'(push) - (PW+1)'(pop);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         color_q      <= '0;
         frag_cnt     <= '0;
         clip_cnt     <= '0;
         overflow_q   <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         if (start) color_q <= i_color;
         frag_cnt     <= sat_inc(start ? 16'd0 : frag_cnt, push);
         clip_cnt     <= sat_inc(start ? 16'd0 : clip_cnt, clip);
         frame_done_q <= drain_done;
         if (drop)         overflow_q <= 1'b1;
         else if (i_clear) overflow_q <= 1'b0;
      end
   end

   assign head         = fifo_empty ? '0 : fifo_mem[rd_ptr];
   assign o_mem_valid  = !fifo_empty;
   assign o_mem_addr   = head[EW-1:COLOR_WIDTH];
   assign o_mem_data   = head[COLOR_WIDTH-1:0];
   assign o_busy       = (state != ST_IDLE);
   assign o_frame_done = frame_done_q;
   assign o_overflow   = overflow_q;
   assign o_frag_count = frag_cnt;
   assign o_clip_count = clip_cnt;

endmodule
